// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dac_pkg
// Description : Shared definitions for the audio DAC path (dac_counter and
//               dac_pwm_out): sample width, PWM state encoding and a helper
//               for sizing the prescale counter.
// Revision    : 1.0 - initial release
// ============================================================================
package dac_pkg;

  // Sample / duty width shared by every block on the sound path.
  localparam int DAC_WIDTH = 8;

  // PWM stage operating state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dac_state_t;

  // Width of a counter that must hold 0..p-1; never narrower than one bit
  // so that PRESCALE=1 still yields a legal vector.
  function automatic int dac_cnt_width(input int p);
    int w;
    w = $clog2(p);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : dac_pkg
`default_nettype wire

// File: rtl/dac_pwm_out_if.sv
`default_nettype none
// ============================================================================
// Interface   : dac_pwm_out_if
// Description : Sample hand-off from dac_counter to dac_pwm_out.
//               sample_i     - next duty value (WIDTH bits)
//               sample_valid - sample_i holds a sample
//               sample_ready - consumer's one-entry buffer is empty
//               master: sample producer, slave: PWM stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface dac_pwm_out_if
  import dac_pkg::*;
#(
  parameter int WIDTH = DAC_WIDTH
) ();

  logic [WIDTH-1:0] sample_i;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output sample_i,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_i,
    input  sample_valid,
    output sample_ready
  );

endinterface : dac_pwm_out_if
`default_nettype wire

// File: rtl/dac_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : dac_tick_gen
// Description : PWM prescaler. Produces a one-clock tick every PRESCALE
//               clocks while run is high; the count is held at zero otherwise.
// Ports       : clk  - system clock
//               nRst - synchronous active-low reset
//               run  - count enable (PWM stage is in RUN or DRAIN)
//               tick - high on the last clock of each prescale interval
// Revision    : 1.0 - initial release
// ============================================================================
module dac_tick_gen
  import dac_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic nRst,
  input  logic run,
  output logic tick
);

  localparam int                 c_cnt_w = dac_cnt_width(PRESCALE);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PRESCALE - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               w_wrap;

  assign w_wrap = (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_cnt <= '0;
    end else if (!run || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // With PRESCALE=1 the count stays at zero and every running clock ticks.
  assign tick = run & w_wrap;

endmodule : dac_tick_gen
`default_nettype wire

// File: rtl/dac_pwm_out.sv
`default_nettype none
// ============================================================================
// Module      : dac_pwm_out
// Description : Audio PWM output stage. Accepts WIDTH-bit samples into a
//               one-entry buffer, loads them as the duty at each PWM period
//               boundary and drives a registered 1-bit PWM line.
// Ports       : clk          - system clock
//               nRst         - synchronous active-low reset
//               enable       - run request
//               smp          - sample handshake (slave side)
//               pwm_o        - registered PWM output
//               at_max       - one-clock pulse after each period boundary
//               underrun     - sticky, boundary reached with empty buffer
//               clr_underrun - clears underrun (a same-edge set wins)
// Revision    : 1.0 - initial release
// ============================================================================
module dac_pwm_out
  import dac_pkg::*;
#(
  parameter int WIDTH    = DAC_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          enable,
  dac_pwm_out_if.slave  smp,
  output logic          pwm_o,
  output logic          at_max,
  output logic          underrun,
  input  logic          clr_underrun
);

  localparam logic [WIDTH-1:0] c_tick_max = {WIDTH{1'b1}};

  dac_state_t       r_state;
  dac_state_t       w_state_nxt;
  logic             w_run;
  logic             w_tick;
  logic             w_boundary;
  logic             w_accept;
  logic [WIDTH-1:0] w_sample;

  logic [WIDTH-1:0] r_tick_cnt;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_buf;
  logic             r_buf_full;
  logic             r_pwm;
  logic             r_at_max;
  logic             r_underrun;

  // --------------------------------------------------------------------------
  // Prescaler
  // --------------------------------------------------------------------------
  dac_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .nRst (nRst),
    .run  (w_run),
    .tick (w_tick)
  );

  // Last tick of a period; only possible while counting.
  assign w_boundary = w_run & w_tick & (r_tick_cnt == c_tick_max);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // Dropping enable exactly on a boundary needs no drain period.
        if (!enable) begin
          w_state_nxt = w_boundary ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        // The period being drained always ends the run, even if enable
        // comes back on the boundary clock itself.
        if (w_boundary) begin
          w_state_nxt = IDLE;
        end else if (enable) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_run = 1'b0;
    unique case (r_state)
      RUN, DRAIN: w_run = 1'b1;
      default:    w_run = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Period counter: held at zero while idle so a new run starts a full period.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_tick_cnt <= '0;
    end else if (!w_run) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Sample buffer and duty register
  // --------------------------------------------------------------------------
  assign w_sample         = smp.sample_i;
  assign smp.sample_ready = ~r_buf_full;
  assign w_accept         = smp.sample_valid & ~r_buf_full;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_duty     <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (w_boundary && r_buf_full) begin
      // Buffer is full, so no accept can coincide with this load.
      r_duty     <= r_buf;
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      // Also covers an accept on a boundary with an empty buffer: the
      // sample waits for the next period and duty is left unchanged.
      r_buf      <= w_sample;
      r_buf_full <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_pwm      <= 1'b0;
      r_at_max   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_pwm    <= w_run & (r_tick_cnt < r_duty);
      r_at_max <= w_boundary;
      if (w_boundary && !r_buf_full) begin
        r_underrun <= 1'b1;
      end else if (clr_underrun) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign pwm_o    = r_pwm;
  assign at_max   = r_at_max;
  assign underrun = r_underrun;

endmodule : dac_pwm_out
`default_nettype wire

// File: tb/tb_dac_pwm_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_pwm_out
// Description : Self-checking bench for dac_pwm_out (WIDTH=8, PRESCALE=1).
//               A per-clock behavioural model (period position, a sample
//               queue and the duty in force) is compared against every
//               output each clock; directed sequences add period-level
//               checks of duty, handshake, underrun, drain and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_pwm_out;
  import dac_pkg::*;

  localparam int W      = DAC_WIDTH;
  localparam int PERIOD = 1 << W;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic nRst;
  logic enable;
  logic clr_underrun;
  logic pwm_o;
  logic at_max;
  logic underrun;

  dac_pwm_out_if #(.WIDTH(W)) smp_if ();

  dac_pwm_out #(
    .WIDTH    (W),
    .PRESCALE (1)
  ) dut (
    .clk          (tb_clk),
    .nRst         (nRst),
    .enable       (enable),
    .smp          (smp_if),
    .pwm_o        (pwm_o),
    .at_max       (at_max),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural reference: position within the period, whether the output
  // is running and whether a stop has been requested, the duty in force and
  // a queue holding at most one waiting sample.
  // --------------------------------------------------------------------------
  bit m_on, m_stop, m_pwm, m_at, m_und;
  int m_pos, m_duty;
  int m_q[$];

  function automatic void model_step(bit rst_n, bit en, bit valid, int d, bit clr);
    bit bnd, empty, acc;
    if (!rst_n) begin
      m_on = 0; m_stop = 0; m_pos = 0; m_duty = 0;
      m_q.delete();
      m_pwm = 0; m_at = 0; m_und = 0;
      return;
    end
    bnd   = m_on && (m_pos == PERIOD - 1);
    empty = (m_q.size() == 0);
    acc   = valid && empty;
    m_pwm = m_on && (m_pos < m_duty);
    m_at  = bnd;
    if (bnd && empty) m_und = 1;
    else if (clr)     m_und = 0;
    if (bnd && !empty) m_duty = m_q.pop_front();
    if (acc)           m_q.push_back(d);
    if (!m_on) begin
      if (en) begin m_on = 1; m_stop = 0; m_pos = 0; end
    end else begin
      m_pos = (m_pos + 1) % PERIOD;
      if (bnd && (!en || m_stop)) begin m_on = 0; m_stop = 0; end
      else m_stop = !en;
    end
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic cyc(input bit rst_n, input bit en, input bit valid,
                     input logic [7:0] d, input bit clr);
    nRst                = rst_n;
    enable              = en;
    smp_if.sample_valid = valid;
    smp_if.sample_i     = d;
    clr_underrun        = clr;
    @(posedge tb_clk);
    model_step(rst_n, en, valid, int'(d), clr);
    #1;
    check("model_pwm",      pwm_o,               m_pwm);
    check("model_at_max",   at_max,              m_at);
    check("model_underrun", underrun,            m_und);
    check("model_ready",    smp_if.sample_ready, (m_q.size() == 0));
  endtask

  // Run with enable high until at_max; checks the clock count to get there.
  task automatic wait_at_max(input string tag, input int limit, input int exp_n);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < limit) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      n++;
      seen = (at_max === 1'b1);
    end
    check({tag, "_at_max_seen"},  seen, 1);
    check({tag, "_at_max_clock"}, n,    exp_n);
  endtask

  int feed[$];

  // One full period starting right after an at_max sample, feeding samples
  // from 'feed' with sample_valid held while any remain.
  task automatic run_period(input string tag, input bit clr_first,
                            output int highs, output int accepts);
    int stray;
    bit at_last;
    stray = 0; at_last = 0; highs = 0; accepts = 0;
    for (int i = 0; i < PERIOD; i++) begin
      bit v, rdy;
      logic [7:0] d;
      v   = (feed.size() > 0);
      d   = v ? 8'(feed[0]) : 8'h00;
      rdy = smp_if.sample_ready;
      cyc(1'b1, 1'b1, v, d, clr_first && (i == 0));
      if (v && rdy) begin
        void'(feed.pop_front());
        accepts++;
      end
      if (pwm_o === 1'b1) highs++;
      if (i < PERIOD - 1 && at_max !== 1'b0) stray++;
      if (i == PERIOD - 1) at_last = (at_max === 1'b1);
    end
    check({tag, "_stray_at_max"}, stray,   0);
    check({tag, "_at_max_end"},   at_last, 1);
  endtask

  typedef struct {
    string      name;
    bit         rst_n, en, valid;
    logic [7:0] d;
    bit         clr;
    bit         e_ready, e_pwm, e_at, e_und;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int highs, acc, n;
    bit en_r;

    //            name           rst en val  d    clr  rdy pwm at und
    tbl[0] = '{"reset0",        0, 0, 0, 8'd0,  0,   1,  0,  0, 0};
    tbl[1] = '{"reset1",        0, 0, 0, 8'd0,  0,   1,  0,  0, 0};
    tbl[2] = '{"idle_accept",   1, 0, 1, 8'd64, 0,   0,  0,  0, 0};
    tbl[3] = '{"idle_hold",     1, 0, 0, 8'd0,  0,   0,  0,  0, 0};
    tbl[4] = '{"enter_run",     1, 1, 0, 8'd0,  0,   0,  0,  0, 0};
    tbl[5] = '{"run_duty0",     1, 1, 0, 8'd0,  0,   0,  0,  0, 0};
    tbl[6] = '{"run_clr",       1, 1, 0, 8'd0,  1,   0,  0,  0, 0};

    nRst = 0; enable = 0; clr_underrun = 0;
    smp_if.sample_valid = 0; smp_if.sample_i = '0;
    #1;

    foreach (tbl[k]) begin
      cyc(tbl[k].rst_n, tbl[k].en, tbl[k].valid, tbl[k].d, tbl[k].clr);
      check({tbl[k].name, "_ready"},    smp_if.sample_ready, tbl[k].e_ready);
      check({tbl[k].name, "_pwm"},      pwm_o,               tbl[k].e_pwm);
      check({tbl[k].name, "_at_max"},   at_max,              tbl[k].e_at);
      check({tbl[k].name, "_underrun"}, underrun,            tbl[k].e_und);
    end

    // First boundary is a full period after entering RUN (2 clocks used).
    wait_at_max("first", 300, PERIOD - 2);

    // Steady duty 64.
    run_period("steady64", 1'b0, highs, acc);
    check("steady64_highs", highs, 64);

    // Handshake: 10, 20, 30 with valid held; one accept per period.
    feed = '{10, 20, 30};
    run_period("hs_p1", 1'b0, highs, acc);
    check("hs_p1_highs", highs, 64);  check("hs_p1_accepts", acc, 1);
    run_period("hs_p2", 1'b0, highs, acc);
    check("hs_p2_highs", highs, 10);  check("hs_p2_accepts", acc, 1);
    run_period("hs_p3", 1'b0, highs, acc);
    check("hs_p3_highs", highs, 20);  check("hs_p3_accepts", acc, 1);
    run_period("hs_p4", 1'b0, highs, acc);
    check("hs_p4_highs", highs, 30);  check("hs_p4_accepts", acc, 0);
    check("hs_p4_underrun", underrun, 1);

    // Underrun: clear, load 100, then starve.
    feed = '{100};
    run_period("ur_p1", 1'b1, highs, acc);
    check("ur_p1_highs", highs, 30);  check("ur_p1_underrun", underrun, 0);
    run_period("ur_p2", 1'b0, highs, acc);
    check("ur_p2_highs", highs, 100); check("ur_p2_underrun", underrun, 1);
    run_period("ur_p3", 1'b0, highs, acc);
    check("ur_p3_highs_hold", highs, 100);

    // Edge duties 0 and 255.
    feed = '{0};
    run_period("edge_load0", 1'b1, highs, acc);
    feed = '{255};
    run_period("edge_d0", 1'b0, highs, acc);
    check("edge_d0_highs", highs, 0);
    run_period("edge_d255", 1'b0, highs, acc);
    check("edge_d255_lows", PERIOD - highs, 1);

    // Disable at tick 50: drain to the boundary, then idle.
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    n = 0; highs = 0;
    while (at_max !== 1'b1 && n < 300) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      n++;
      if (pwm_o === 1'b1) highs++;
    end
    check("drain_at_max_clock", n, PERIOD - 50);
    check("drain_highs", highs, 205);
    highs = 0; acc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      if (pwm_o === 1'b1) highs++;
      if (at_max === 1'b1) acc++;
    end
    check("idle_pwm_highs", highs, 0);
    check("idle_at_max",    acc,   0);

    // Reset at tick 120 with a sample buffered; the sample must be lost.
    cyc(1'b1, 1'b0, 1'b1, 8'd77, 1'b0);
    for (int i = 0; i < 121; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("rst120_pwm",      pwm_o,               0);
    check("rst120_at_max",   at_max,              0);
    check("rst120_underrun", underrun,            0);
    check("rst120_ready",    smp_if.sample_ready, 1);
    wait_at_max("post_rst", 300, PERIOD + 1);
    check("post_rst_underrun", underrun, 1);
    run_period("post_rst", 1'b0, highs, acc);
    check("post_rst_highs", highs, 0);

    // Randomised traffic against the model.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit rst_n, v, c;
      if ($urandom_range(0, 299) == 0) en_r = !en_r;
      // Keep clear of a re-enable landing exactly on a drain boundary.
      if (m_on && m_stop && m_pos == PERIOD - 1) en_r = 1'b0;
      rst_n = ($urandom_range(0, 1999) != 0);
      v     = ($urandom_range(0, 99) < 3);
      c     = ($urandom_range(0, 49) == 0);
      cyc(rst_n, en_r, v, 8'($urandom), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dac_pwm_out
`default_nettype wire

// File: doc/dac_pwm_out.md
# dac_pwm_out

Audio output stage for the game's sound path: consumes 8-bit samples and drives a 1-bit PWM line into the off-chip RC filter. It is the downstream end of `dac_counter`: it accepts each sample over a valid/ready handshake into a one-entry buffer. It also generates the one-cycle `at_max` pulse at every PWM period boundary, which `dac_counter` uses to advance to the next sample.

## Interface
Parameters:
- `WIDTH`, 8, sample/duty width; PWM period is 2^WIDTH ticks
- `PRESCALE`, 1, clocks per PWM tick (≥1)

Ports:
- `clk`  in  1  system clock
- `nRst`  in  1  reset, synchronous, active-low
- `enable`  in  1  run request
- `sample_i`  in  WIDTH  next duty value
- `sample_valid`  in  1  `sample_i` valid
- `sample_ready`  out  1  one-entry buffer empty
- `pwm_o`  out  1  PWM output
- `at_max`  out  1  one-cycle pulse, period complete
- `underrun`  out  1  sticky, boundary hit with empty buffer
- `clr_underrun`  in  1  clears `underrun`

## Operation
- Reset (sampled `nRst`=0 at posedge) gives:
  - state IDLE, prescale count 0, tick count 0, duty 0, buffer empty
  - `pwm_o`=0, `at_max`=0, `underrun`=0
  - `sample_ready`=1 is combinational from the empty buffer.
- FSM states IDLE, RUN, DRAIN:
  - IDLE: counters held at 0 and `pwm_o`=0. `enable`=1 moves to RUN on the next edge.
  - RUN: counters advance.
    - `enable`=0 moves to DRAIN without a period boundary.
    - `enable`=0 coinciding with a boundary moves straight to IDLE.
  - DRAIN: finishes the current period.
    - At the boundary → IDLE, and `at_max` pulses.
    - `enable` reasserted during DRAIN → RUN on the next edge; the period is not restarted.
- Tick: asserted when the prescale count = PRESCALE-1; the prescale count then wraps to 0.
  - Tick count increments per tick and wraps from 2^WIDTH-1 to 0.
- Boundary: tick with tick count = 2^WIDTH-1, in RUN or DRAIN.
- Handshake:
  - Accept on `sample_valid & sample_ready` at a posedge.
  - The buffer becomes full, and `sample_ready` drops in the following cycle.
  - The buffer is accepted in any state, including IDLE.
- At a boundary:
  - Buffer full: duty ← buffer, buffer empties, `sample_ready` rises next cycle.
  - Buffer empty: duty is unchanged and `underrun` is set.
  - An accept on the same edge as the boundary while the buffer is empty lands in the buffer, not in duty. `underrun` is still set.
- `pwm_o` = (tick count < duty) in RUN/DRAIN, registered.
  - duty 0 → constant 0.
  - duty 2^WIDTH-1 → high for 255 of 256 ticks.
- `underrun` clears on `clr_underrun`. If a set and a clear occur on the same edge, the set wins.
- Width rules:
  - All compares are unsigned WIDTH-bit.
  - The prescale counter is $clog2(PRESCALE) bits, minimum 1.

## Timing
- `pwm_o` registered: reflects the tick count/duty from the previous edge, so there is 1 clock of latency.
- `at_max` registered: high exactly one clock, in the clock after the boundary edge.
- New duty takes effect on the first tick of the new period; there is no mid-period duty change.
- Period = PRESCALE·2^WIDTH clocks. First boundary falls PRESCALE·2^WIDTH clocks after entering RUN.
- Reset mid-operation: all state returns to reset values on that edge, and any buffered sample is discarded.

## Structure
- Package `dac_pkg`:
  - `DAC_WIDTH`=8
  - `dac_state_t` enum {IDLE, RUN, DRAIN}
  - shared with `dac_counter` for the sample width
- Sub-module `dac_tick_gen` (parameter PRESCALE; ports `clk`, `nRst`, `run`, `tick`): the prescaler. Everything else lives in the top.

## Test plan
- Reset: hold `nRst`=0 for 2 clocks → `pwm_o`=0, `at_max`=0, `underrun`=0, `sample_ready`=1.
- Steady PWM: PRESCALE=1, load 64, enable → next period `pwm_o` is high for exactly 64 of 256 clocks, and `at_max` pulses every 256 clocks.
- Handshake: `sample_valid` held high with values 10, 20, 30 → one accept per period (`sample_ready` low between boundaries), and the duties apply in order.
- Underrun: load 100, then no further samples → the second boundary sets `underrun`=1 and duty stays 100. `clr_underrun` → 0.
- Edge duties: duty 0 → `pwm_o` is never high. Duty 255 → `pwm_o` is low exactly 1 clock per period.
- Disable/reset mid-period: `enable`=0 at tick 50 → DRAIN, then `at_max` at tick 255, then IDLE with `pwm_o`=0. Separately, `nRst`=0 at tick 120 → all outputs at reset values on the next edge.
